// File: rtl/mod_arith_pkg.sv
// Shared types and constants for the mod-q arithmetic datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mod_arith_pkg;

    localparam int Q_W  = 23;
    localparam int OP_W = 24;

    localparam logic [Q_W-1:0] Q_DILITHIUM = 23'd8380417;

    typedef logic [Q_W-1:0]  coef_t;
    typedef logic [OP_W-1:0] op_t;

    // Operand bundle handed from the grant mux to the adder.
    typedef struct packed {
        op_t   a;
        op_t   b;
        coef_t q;
    } add_req_t;

endpackage

// File: rtl/mod_add.sv
// Modular adder: c = (a+b < q) ? a+b : a+b-q, truncated to the coefficient width.
// Latency: combinational.
// Backpressure: none.
module mod_add
    import mod_arith_pkg::*;
(
    input  add_req_t req_dat,
    output coef_t    c_dat
);

    logic [OP_W:0] sum;
    logic [OP_W:0] diff;
    logic [OP_W:0] q_ext;

    assign q_ext = {2'b00, req_dat.q};
    assign sum   = {1'b0, req_dat.a} + {1'b0, req_dat.b};
    assign diff  = sum - q_ext;

    // Single conditional subtraction; out-of-range operands simply truncate.
    assign c_dat = (sum < q_ext) ? sum[Q_W-1:0] : diff[Q_W-1:0];

endmodule

// File: rtl/mod_add_arbiter.sv
// Round-robin arbiter sharing one mod_add between NREQ requesters, tagged result register.
// Latency: accept in cycle N -> res_valid_o with that result in cycle N+1.
// Backpressure: requests only accepted when the result slot is empty or draining this cycle.
module mod_add_arbiter
    import mod_arith_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  coef_t                q_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  op_t  [NREQ-1:0]      req_a_i,
    input  op_t  [NREQ-1:0]      req_b_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output coef_t                res_c_o,
    output logic [ID_W-1:0]      res_id_o,
    output logic [15:0]          ops_cnt_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_t;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } grant_t;

    typedef struct packed {
        coef_t           c;
        logic [ID_W-1:0] id;
    } res_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    // First valid index at or after ptr, cyclically; descending scan lets the
    // smallest offset from ptr overwrite any later candidate.
    function automatic grant_t rr_grant(input logic [NREQ-1:0] vld,
                                        input logic [ID_W-1:0] ptr_v);
        grant_t          g;
        logic [ID_W-1:0] idx;
        g = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr_v) + k) % NREQ);
            if (vld[idx]) begin
                g.vld = 1'b1;
                g.id  = idx;
            end
        end
        return g;
    endfunction

    res_state_t      state;
    res_state_t      state_nxt;
    logic [ID_W-1:0] ptr;
    res_t            res_q;
    grant_t          grant;
    logic            slot_free;
    logic            accept;
    add_req_t        add_req;
    coef_t           add_c;

    mod_add u_mod_add (
        .req_dat (add_req),
        .c_dat   (add_c)
    );

    always_comb begin
        grant       = rr_grant(req_valid_i, ptr);
        slot_free   = (state == ST_EMPTY) || res_ready_i;
        accept      = grant.vld && slot_free && !rst_i;
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant.id] = 1'b1;
        end

        add_req.a = req_a_i[grant.id];
        add_req.b = req_b_i[grant.id];
        add_req.q = q_i;

        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL:  if (res_ready_i && !accept) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_EMPTY;
            ptr       <= '0;
            res_q     <= '0;
            ops_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                res_q.c   <= add_c;
                res_q.id  <= grant.id;
                ptr       <= (grant.id == LAST_ID) ? '0 : grant.id + 1'b1;
                ops_cnt_o <= ops_cnt_o + 16'd1;
            end
        end
    end

    assign res_valid_o = (state == ST_FULL);
    assign res_c_o     = res_q.c;
    assign res_id_o    = res_q.id;

endmodule

// File: tb/tb_mod_add_arbiter.sv
// Randomized and directed bench for mod_add_arbiter against a queue-free behavioural model.
module tb_mod_add_arbiter;

    localparam int NREQ = 2;
    localparam logic [22:0] QD = 23'd8380417;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [22:0]           q;
    logic [NREQ-1:0]       valid;
    logic [NREQ-1:0][23:0] a;
    logic [NREQ-1:0][23:0] b;
    logic [NREQ-1:0]       ready_o;
    logic                  res_valid;
    logic                  res_ready;
    logic [22:0]           res_c;
    logic [0:0]            res_id;
    logic [15:0]           ops_cnt;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    bit          m_valid = 1'b0;
    logic [22:0] m_c     = '0;
    int          m_id    = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;

    mod_add_arbiter #(.NREQ(NREQ)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .q_i         (q),
        .req_valid_i (valid),
        .req_a_i     (a),
        .req_b_i     (b),
        .req_ready_o (ready_o),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_c_o     (res_c),
        .res_id_o    (res_id),
        .ops_cnt_o   (ops_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [22:0] model_sum(input logic [23:0] x, input logic [23:0] y,
                                              input logic [22:0] qq);
        longint s;
        s = longint'(x) + longint'(y);
        if (s >= longint'(qq)) s = s - longint'(qq);
        return 23'(s);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_c     = '0;
            m_id    = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else begin
            int g;
            g = model_grant(valid, m_ptr);
            if (g >= 0 && (!m_valid || res_ready)) begin
                m_c     = model_sum(a[g], b[g], q);
                m_id    = g;
                m_valid = 1'b1;
                m_ptr   = (g + 1) % NREQ;
                m_cnt   = (m_cnt + 1) % 65536;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int g;
            logic [NREQ-1:0] er;
            g  = model_grant(valid, m_ptr);
            er = '0;
            if (!rst && g >= 0 && (!m_valid || res_ready)) er[g] = 1'b1;
            check("req_ready", 32'(ready_o), 32'(er));
            check("res_valid", 32'(res_valid), 32'(m_valid));
            check("ops_cnt", 32'(ops_cnt), 32'(m_cnt));
            check("ptr", 32'(dut.ptr), 32'(m_ptr));
            if (m_valid) begin
                check("res_c", 32'(res_c), 32'(m_c));
                check("res_id", 32'(res_id), 32'(m_id));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [23:0] rand_op(input logic [22:0] qq);
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 5) return 24'($urandom_range(0, int'(qq) - 1));
        if (sel < 8) return 24'($urandom);
        if (sel == 8) return {1'b0, qq} - 24'd1;
        return 24'hFFFFFF;
    endfunction

    initial begin
        int ids[4] = '{0, 1, 0, 1};
        logic [NREQ-1:0] acc;
        q         = QD;
        res_ready = 1'b1;
        valid     = '0;
        a         = '0;
        b         = '0;

        #1 rst = 1'b1;
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_c", 32'(res_c), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_ops_cnt", 32'(ops_cnt), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        step();
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Single request
        valid = 2'b01; a[0] = 24'd5; b[0] = 24'd7;
        step();
        valid = '0;
        @(negedge clk);
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_c", 32'(res_c), 32'd12);
        check("single_id", 32'(res_id), 32'd0);
        check("single_cnt", 32'(ops_cnt), 32'd1);

        // Modular wrap corners
        step(); valid = 2'b01; a[0] = 24'd8380416; b[0] = 24'd1;
        step(); valid = '0;
        @(negedge clk); check("wrap_q", 32'(res_c), 32'd0);
        step(); valid = 2'b01; a[0] = 24'd8380416; b[0] = 24'd8380416;
        step(); valid = '0;
        @(negedge clk); check("wrap_max", 32'(res_c), 32'd8380415);
        step(); valid = 2'b01; a[0] = 24'd0; b[0] = 24'd0;
        step(); valid = '0;
        @(negedge clk); check("wrap_zero", 32'(res_c), 32'd0);

        // Fairness: both valid every cycle from ptr = 0
        do_reset();
        valid = 2'b11; a[0] = 24'd1; b[0] = 24'd1; a[1] = 24'd2; b[1] = 24'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("fair_valid", 32'(res_valid), 32'd1);
            check("fair_id", 32'(res_id), 32'(ids[i]));
        end
        step(); valid = '0;

        // Backpressure then drain+accept in one cycle
        do_reset();
        valid = 2'b01; a[0] = 24'd5; b[0] = 24'd7;
        step();
        res_ready = 1'b0;
        valid = 2'b10; a[1] = 24'd100; b[1] = 24'd200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_c", 32'(res_c), 32'd12);
            check("bp_id", 32'(res_id), 32'd0);
            check("bp_ready", 32'(ready_o), 32'd0);
            check("bp_ptr", 32'(dut.ptr), 32'd1);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("drain_ready", 32'(ready_o), 32'b10);
        step(); valid = '0;
        @(negedge clk);
        check("drain_c", 32'(res_c), 32'd300);
        check("drain_id", 32'(res_id), 32'd1);

        // Asynchronous reset while holding a result with ptr = 1
        step(); valid = 2'b01; a[0] = 24'd1; b[0] = 24'd2;
        step(); valid = '0; res_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_ptr", 32'(dut.ptr), 32'd1);
        check("pre_rst_valid", 32'(res_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(res_valid), 32'd0);
        check("arst_c", 32'(res_c), 32'd0);
        check("arst_id", 32'(res_id), 32'd0);
        check("arst_ptr", 32'(dut.ptr), 32'd0);
        check("arst_cnt", 32'(ops_cnt), 32'd0);
        step();
        rst = 1'b0; res_ready = 1'b1;
        valid = 2'b10; a[1] = 24'd3; b[1] = 24'd4;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_o), 32'b10);
        step(); valid = '0;
        @(negedge clk);
        check("post_rst_c", 32'(res_c), 32'd7);
        check("post_rst_id", 32'(res_id), 32'd1);

        // Counter wrap after 65536 accepts
        do_reset();
        valid = 2'b01; a[0] = 24'd1; b[0] = 24'd1;
        repeat (65535) step();
        @(negedge clk);
        check("cnt_ffff", 32'(ops_cnt), 32'hFFFF);
        step(); valid = '0;
        @(negedge clk);
        check("cnt_wrap", 32'(ops_cnt), 32'd0);

        // Random regression
        q = QD;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            acc = valid & ready_o;
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !valid[i]) begin
                    valid[i] = ($urandom_range(0, 9) < 6);
                    a[i]     = rand_op(q);
                    b[i]     = rand_op(q);
                end
            end
            res_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) q = 23'($urandom_range(2, 8388607));
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_add_arbiter.md
# mod_add_arbiter

Round-robin arbiter and sequencer sharing one modular adder (`mod_add`) between `NREQ` requesters, e.g. NTT butterfly lanes and polynomial-add engines working mod q (23-bit q, Dilithium q = 8380417).
- Each requester presents an operand pair with a valid/ready handshake.
- The winner's operands go through the adder, and the result is captured in a single output register with requester tag and backpressure.
- An operation counter is provided for performance monitoring.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, ≥2.
- `ID_W`, `$clog2(NREQ)`: width of the requester tag.

Ports:
- `clk_i`  in  1: single clock, rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `q_i`  in  23: modulus. Sampled only in an accept cycle.
- `req_valid_i`  in  `NREQ`: request valid, one bit per requester.
- `req_a_i`  in  `NREQ`×24: operand a per requester.
- `req_b_i`  in  `NREQ`×24: operand b per requester.
- `req_ready_o`  out  `NREQ`: one-hot or zero. The request is accepted when valid & ready.
- `res_valid_o`  out  1: result register holds a result.
- `res_ready_i`  in  1: consumer accepts the result.
- `res_c_o`  out  23: modular sum.
- `res_id_o`  out  `ID_W`: index of the requester that produced `res_c_o`.
- `ops_cnt_o`  out  16: count of accepted requests, wraps.

## Operation
- **Arithmetic.** s = a + b (25-bit). c = (s < q) ? s : s − q, truncated to 23 bits. The result equals (a+b) mod q when a, b < q. Out-of-range operands get exactly this single-subtraction rule; no error is flagged.
- **Arbitration.** A priority pointer `ptr` (`ID_W` bits) names the highest-priority requester. The grant goes to the first valid index at or after `ptr`, cyclically.
- **Pointer update.** On accept by requester g, `ptr` ← (g+1) mod `NREQ`. With no accept, `ptr` holds.
- **Ready rule.** `req_ready_o[g]` = 1 only for the granted g, and only when slot_free = !`res_valid_o` | `res_ready_i`.
  - `req_ready_o` depends combinationally on `req_valid_i`, so requesters must not derive valid from ready.
  - Requesters hold valid, a and b stable until accepted.
- **Output register FSM** (state = `res_valid_o`):
  - EMPTY → FULL on accept.
  - FULL & `res_ready_i` & accept → FULL, loaded with the new result and id.
  - FULL & `res_ready_i` & no accept → EMPTY.
  - FULL & !`res_ready_i` → FULL. `res_c_o` and `res_id_o` are held stable and all `req_ready_o` = 0.
- **Counter.** `ops_cnt_o` increments by 1 on each accept and wraps from 0xFFFF to 0x0000.

## Timing
- **Latency.** The accept in cycle N gives `res_valid_o` = 1 in cycle N+1 with that result.
- **Throughput.** One operation per cycle when `res_ready_i` = 1.
- **Drain and accept together.** In the same cycle they are legal and lose no bubble.
- **Reset values.** `res_valid_o` = 0, `res_c_o` = 0, `res_id_o` = 0, `ptr` = 0, `ops_cnt_o` = 0. `req_ready_o` = 0 while `rst_i` = 1.
- **Reset mid-operation.** Asserting `rst_i` clears state immediately (asynchronous). A held result is discarded and no handshake completes during reset. The first accept is possible in the first cycle after deassertion.
- **Single requester valid.** It is granted regardless of `ptr`.
- **No requester valid.** No grant is made and `ptr` is unchanged.

## Structure
- Package `mod_arith_pkg` holds:
  - `Q_W` = 23 and `OP_W` = 24.
  - `Q_DILITHIUM` = 23'd8380417.
  - typedefs `coef_t` (logic[22:0]) and `op_t` (logic[23:0]).
- One instance of the existing `mod_add` sub-module, fed by the grant mux. No other sub-modules.
- The round-robin grant is a function inside the block.

## Test plan
Unless stated otherwise, q = 8380417 and `res_ready_i` = 1.
1. **Single request.** req0 a = 5, b = 7 → next cycle `res_valid_o` = 1, `res_c_o` = 12, `res_id_o` = 0, `ops_cnt_o` = 1.
2. **Modular wrap.**
   - a = 8380416, b = 1 → `res_c_o` = 0.
   - a = 8380416, b = 8380416 → `res_c_o` = 8380415.
   - a = 0, b = 0 → 0.
3. **Fairness.** `NREQ` = 2, both valid every cycle → grants alternate 0,1,0,1. One result per cycle, with `res_id_o` sequence 0,1,0,1.
4. **Backpressure.**
   - `res_ready_i` = 0 for 3 cycles with result 12 held → `res_c_o` and `res_id_o` stable, all `req_ready_o` = 0, `ptr` unchanged.
   - Raising `res_ready_i` → drain and new accept in the same cycle.
5. **Reset mid-operation.** `rst_i` pulsed while `res_valid_o` = 1 and `ptr` = 1 → outputs return to 0 asynchronously, `ptr` = 0. The next request from req1 alone is still granted.
6. **Counter wrap.** 65536 accepted requests → `ops_cnt_o` = 0. Random regression compares every result against the arithmetic rule.
